// File: rtl/video_capture.sv
// video_capture: decimates a pix_en-qualified raster (vs/de/rgb) into a WIDTH x HEIGHT image,
//   keeping the centre pixel of each BLOCK x BLOCK tile of a centred window, one frame per start.
// Latency: a kept sample is presented on wr_* one CLOCK_50 cycle after the pix_en edge that sampled it.
// Backpressure: single write register held until wr_ready; a sample that arrives while it is
//   still unaccepted is dropped and sets the sticky overflow flag (the pending write is kept).
//
// Ports:
//   CLOCK_50            system clock, all logic on posedge
//   reset_n             synchronous active-low reset
//   pix_en              source pixel strobe; vs/de/r/g/b are only sampled when high
//   vs, de              vertical sync pulse / data enable of the source raster
//   r, g, b             source pixel colour
//   start               one-cycle request to capture the next full frame (ignored unless idle)
//   busy                high while waiting for vs or capturing
//   wr_en / wr_ready    frame-buffer write valid / accept
//   wr_x, wr_y          output column / row of the pending write
//   wr_r, wr_g, wr_b    sampled colour of the pending write
//   frame_done          one-cycle pulse when a capture completes
//   overflow            sticky dropped-sample flag, cleared by an accepted start

module video_capture #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28,
  parameter int SRC_W  = 640,
  parameter int SRC_H  = 480
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       pix_en,
  input  logic       vs,
  input  logic       de,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  input  logic       start,
  output logic       busy,
  output logic       wr_en,
  input  logic       wr_ready,
  output logic [9:0] wr_x,
  output logic [8:0] wr_y,
  output logic [7:0] wr_r,
  output logic [7:0] wr_g,
  output logic [7:0] wr_b,
  output logic       frame_done,
  output logic       overflow
);

  // Window geometry: square tiles as large as both axes allow, window centred on the raster.
  localparam int BLOCK   = (SRC_W / WIDTH < SRC_H / HEIGHT) ? SRC_W / WIDTH : SRC_H / HEIGHT;
  localparam int X_START = (SRC_W - WIDTH * BLOCK) / 2;
  localparam int Y_START = (SRC_H - HEIGHT * BLOCK) / 2;
  localparam int OFS     = BLOCK / 2;

  localparam logic [9:0] X_START_C  = 10'(X_START);
  localparam logic [9:0] X_BLK_LAST = 10'(BLOCK - 1);
  localparam logic [9:0] X_OFS      = 10'(OFS);
  localparam logic [9:0] X_TILES    = 10'(WIDTH);
  localparam logic [9:0] COL_LAST   = 10'(WIDTH - 1);

  localparam logic [8:0] Y_START_C  = 9'(Y_START);
  localparam logic [8:0] Y_BLK_LAST = 9'(BLOCK - 1);
  localparam logic [8:0] Y_OFS      = 9'(OFS);
  localparam logic [8:0] Y_TILES    = 9'(HEIGHT);
  localparam logic [8:0] ROW_LAST   = 9'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } wr_dat_t;

  state_t     state;
  state_t     state_nxt;

  // Raster position of the current pixel: xt = pixels already seen on this line,
  // yt = lines already completed since vs.
  logic [9:0] xt;
  logic [8:0] yt;
  logic       de_last;
  logic       vs_last;

  // Position inside the window: tile index (x_out/y_out) and offset within the tile (xd/yd).
  // Only meaningful once xt/yt have reached the window start.
  logic [9:0] xd;
  logic [9:0] x_out;
  logic [8:0] yd;
  logic [8:0] y_out;

  wr_dat_t    wr_dat;
  logic       wr_last;      // pending write is the final pixel of the frame being captured
  logic       wr_acc;
  logic       x_hit;
  logic       y_hit;
  logic       sample_vld;
  logic       vs_rise;
  logic       frame_abort;

  // ---------------------------------------------------------------------------
  // Raster and tile counters (advance only on pix_en)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      xt      <= '0;
      yt      <= '0;
      xd      <= '0;
      x_out   <= '0;
      yd      <= '0;
      y_out   <= '0;
      de_last <= 1'b0;
      vs_last <= 1'b0;
    end else if (pix_en) begin
      de_last <= de;
      vs_last <= vs;

      if (de) begin
        if (xt != 10'h3FF) begin
          xt <= xt + 10'd1;
        end
        if (xt >= X_START_C) begin
          if (xd == X_BLK_LAST) begin
            xd <= '0;
            // Stop at WIDTH so pixels right of the window never match a tile.
            if (x_out != X_TILES) begin
              x_out <= x_out + 10'd1;
            end
          end else begin
            xd <= xd + 10'd1;
          end
        end
      end else begin
        xt    <= '0;
        xd    <= '0;
        x_out <= '0;
      end

      if (vs) begin
        yt    <= '0;
        yd    <= '0;
        y_out <= '0;
      end else if (de_last && !de) begin
        // The line that just ended was line yt; step the vertical tile position past it.
        if (yt != 9'h1FF) begin
          yt <= yt + 9'd1;
        end
        if (yt >= Y_START_C) begin
          if (yd == Y_BLK_LAST) begin
            yd <= '0;
            if (y_out != Y_TILES) begin
              y_out <= y_out + 9'd1;
            end
          end else begin
            yd <= yd + 9'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample selection
  // ---------------------------------------------------------------------------
  always_comb begin
    x_hit       = (xt >= X_START_C) && (xd == X_OFS) && (x_out < X_TILES);
    y_hit       = (yt >= Y_START_C) && (yd == Y_OFS) && (y_out < Y_TILES);
    sample_vld  = (state == CAPTURE) && pix_en && de && !vs && x_hit && y_hit;
    wr_acc      = wr_en && wr_ready;
    // vs spans several pix_en cycles; only its leading edge ends a frame, so a capture
    // that starts inside a vs pulse is not torn down by the rest of that pulse.
    vs_rise     = vs && !vs_last;
    frame_abort = (state == CAPTURE) && pix_en && vs_rise;
  end

  // ---------------------------------------------------------------------------
  // Write register and overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      wr_en    <= 1'b0;
      wr_dat   <= '0;
      wr_last  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // The register is free when empty or being drained on this very edge.
      if (sample_vld && (!wr_en || wr_ready)) begin
        wr_en   <= 1'b1;
        wr_dat  <= '{x: x_out, y: y_out, r: r, g: g, b: b};
        wr_last <= (x_out == COL_LAST) && (y_out == ROW_LAST);
      end else if (wr_acc) begin
        wr_en   <= 1'b0;
        wr_last <= 1'b0;
      end else if (frame_abort) begin
        // A pending write from an abandoned frame still goes out, but it no longer
        // completes a capture.
        wr_last <= 1'b0;
      end

      if ((state == IDLE) && start) begin
        overflow <= 1'b0;
      end else if (sample_vld && wr_en && !wr_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (pix_en && vs) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        // Completion wins over a vs edge that lands on the same cycle.
        if (wr_acc && wr_last) begin
          state_nxt = DONE;
        end else if (frame_abort) begin
          state_nxt = WAIT_VS;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    busy       = (state == WAIT_VS) || (state == CAPTURE);
    frame_done = (state == DONE);
    wr_x       = wr_dat.x;
    wr_y       = wr_dat.y;
    wr_r       = wr_dat.r;
    wr_g       = wr_dat.g;
    wr_b       = wr_dat.b;
  end

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: self-checking bench for video_capture on a scaled raster.
// Latency: n/a (bench).
// Backpressure: wr_ready driven per scenario (always ready, random short stalls, held low).

module tb_video_capture;

  localparam int W      = 4;
  localparam int H      = 3;
  localparam int SW     = 54;
  localparam int SH     = 35;
  localparam int BLK    = (SW / W < SH / H) ? SW / W : SH / H;   // 11
  localparam int XS     = (SW - W * BLK) / 2;                    // 5
  localparam int YS     = (SH - H * BLK) / 2;                    // 1
  localparam int OFS    = BLK / 2;                               // 5
  localparam int HBLANK = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_en = 1'b0;
  logic       vs = 1'b0;
  logic       de = 1'b0;
  logic [7:0] r = '0;
  logic [7:0] g = '0;
  logic [7:0] b = '0;
  logic       start = 1'b0;
  logic       wr_ready = 1'b1;
  logic       busy;
  logic       wr_en;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [7:0] wr_r;
  logic [7:0] wr_g;
  logic [7:0] wr_b;
  logic       frame_done;
  logic       overflow;

  video_capture #(.WIDTH(W), .HEIGHT(H), .SRC_W(SW), .SRC_H(SH)) dut (
    .CLOCK_50  (clk),
    .reset_n   (reset_n),
    .pix_en    (pix_en),
    .vs        (vs),
    .de        (de),
    .r         (r),
    .g         (g),
    .b         (b),
    .start     (start),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_r      (wr_r),
    .wr_g      (wr_g),
    .wr_b      (wr_b),
    .frame_done(frame_done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } wr_t;

  typedef struct {
    bit do_start;
    int ready_mode;
    int pen_pct;
    int exp_writes;
    int exp_done;
    bit exp_ovf;
    bit exp_busy;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         ready_mode = 0;   // 0 ready, 1 random short stalls, 2 never ready, 3 stall first write 3 cycles
  int         pen_pct = 100;
  int         low_run = 0;
  int         hold_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] salt = 8'h5A;
  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic       prev_stall = 1'b0;
  wr_t        prev_dat;
  vec_t       vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: collect accepted writes, count frame_done, and check stalled writes hold.
  always @(negedge clk) begin
    wr_t cur;
    cur = '{x: wr_x, y: wr_y, r: wr_r, g: wr_g, b: wr_b};
    if (reset_n) begin
      if (prev_stall) begin
        check("hold", {20'd0, wr_en, cur}, {20'd0, 1'b1, prev_dat});
      end
      if (wr_en && wr_ready) got_q.push_back(cur);
      if (frame_done) done_cnt++;
      prev_stall = wr_en && !wr_ready;
      prev_dat   = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0: wr_ready = 1'b1;
      1: begin
        if (low_run < 3 && $urandom_range(0, 3) == 0) begin
          wr_ready = 1'b0;
          low_run++;
        end else begin
          wr_ready = 1'b1;
          low_run  = 0;
        end
      end
      2: wr_ready = 1'b0;
      default: begin
        if (wr_en && hold_cnt < 3) begin
          wr_ready = 1'b0;
          hold_cnt++;
        end else begin
          wr_ready = 1'b1;
        end
      end
    endcase
  endtask

  // One source pixel, preceded by a random number of idle (pix_en=0) cycles carrying junk.
  task automatic pixel(input bit v, input bit d, input int x, input int y);
    while ($urandom_range(0, 99) >= pen_pct) begin
      pix_en = 1'b0;
      vs = 1'($urandom);
      de = 1'($urandom);
      {r, g, b} = 24'($urandom);
      tick();
    end
    pix_en = 1'b1;
    vs = v;
    de = d;
    if (d) {r, g, b} = {8'(x), 8'(y), salt};
    else   {r, g, b} = 24'($urandom);
    tick();
    pix_en = 1'b0;
    vs = 1'b0;
    de = 1'b0;
  endtask

  task automatic line_part(input int y, input int x0, input int x1);
    for (int x = x0; x < x1; x++) pixel(1'b0, 1'b1, x, y);
    if (x1 == SW) begin
      for (int k = 0; k < HBLANK; k++) pixel(1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic send_frame(input int nlines);
    for (int k = 0; k < 3; k++) pixel(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 2; k++) pixel(1'b0, 1'b0, 0, 0);
    for (int y = 0; y < nlines; y++) line_part(y, 0, SW);
  endtask

  task automatic flush(input int n);
    pix_en = 1'b0;
    vs = 1'b0;
    de = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Reference: tile (i,j) is the pixel at column XS+i*BLK+OFS of line YS+j*BLK+OFS,
  // emitted row by row; only rows whose line is actually sent appear.
  task automatic expect_frame(input int nlines);
    for (int j = 0; j < H; j++) begin
      for (int i = 0; i < W; i++) begin
        int x;
        int y;
        x = XS + i * BLK + OFS;
        y = YS + j * BLK + OFS;
        if (y < nlines) exp_q.push_back('{x: 10'(i), y: 9'(j), r: 8'(x), g: 8'(y), b: salt});
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_w%0d", tag, k), 64'(got_q[k]), 64'(exp_q[k]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] old_salt;
    wr_t        pick;

    vecs[0] = '{1'b1, 0, 100, 12, 1, 1'b0, 1'b0};  // plain frame, always ready
    vecs[1] = '{1'b1, 3,  80, 12, 1, 1'b0, 1'b0};  // first write stalled 3 cycles
    vecs[2] = '{1'b1, 1,  70, 12, 1, 1'b0, 1'b0};  // random short stalls
    vecs[3] = '{1'b0, 1,  90,  0, 0, 1'b0, 1'b0};  // no start: nothing written
    vecs[4] = '{1'b1, 1,  60, 12, 1, 1'b0, 1'b0};  // sparse pix_en
    vecs[5] = '{1'b0, 0, 100,  0, 0, 1'b0, 1'b0};  // no start again

    // Reset state
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_wr_xy", 64'({wr_x, wr_y}), 64'(0));
    check("rst_wr_rgb", 64'({wr_r, wr_g, wr_b}), 64'(0));
    check("rst_done", 64'(frame_done), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    reset_n = 1'b1;
    tick();

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      ready_mode = vecs[i].ready_mode;
      pen_pct    = vecs[i].pen_pct;
      low_run    = 0;
      hold_cnt   = 0;
      done_cnt   = 0;
      salt       = (i == 0) ? 8'h5A : 8'($urandom);
      if (vecs[i].do_start) begin
        pulse_start();
        expect_frame(SH);
      end
      send_frame(SH);
      flush(8);
      check($sformatf("v%0d_writes", i), 64'(got_q.size()), 64'(vecs[i].exp_writes));
      if (i == 0) begin
        // Hand-derived: (0,0) at xt=10,yt=6; (3,0) at xt=43; (3,2) at xt=43,yt=28.
        pick = (got_q.size() > 0) ? got_q[0] : '1;
        check("first_wr", 64'(pick), 64'({10'd0, 9'd0, 8'h0A, 8'h06, 8'h5A}));
        pick = (got_q.size() > 3) ? got_q[3] : '1;
        check("wr_3_0", 64'(pick), 64'({10'd3, 9'd0, 8'h2B, 8'h06, 8'h5A}));
        pick = (got_q.size() > 11) ? got_q[11] : '1;
        check("last_wr", 64'(pick), 64'({10'd3, 9'd2, 8'h2B, 8'h1C, 8'h5A}));
      end
      compare_writes($sformatf("v%0d", i));
      check($sformatf("v%0d_done", i), 64'(done_cnt), 64'(vecs[i].exp_done));
      check($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].exp_ovf));
      check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
    end

    // Frame buffer never ready: first write stuck, later samples dropped, overflow sticks.
    pen_pct    = 85;
    ready_mode = 2;
    done_cnt   = 0;
    salt       = 8'($urandom);
    old_salt   = salt;
    pulse_start();
    send_frame(SH);
    flush(8);
    check("ovf_set", 64'(overflow), 64'(1));
    check("ovf_wr_en", 64'(wr_en), 64'(1));
    check("ovf_wr_xy", 64'({wr_x, wr_y}), 64'(0));
    check("ovf_wr_rgb", 64'({wr_r, wr_g, wr_b}), 64'({8'(XS + OFS), 8'(YS + OFS), old_salt}));
    check("ovf_no_done", 64'(done_cnt), 64'(0));
    check("ovf_busy", 64'(busy), 64'(1));
    check("ovf_no_writes", 64'(got_q.size()), 64'(0));

    // Releasing backpressure: stale (0,0) drains, then the next frame captures fully.
    ready_mode = 0;
    exp_q.push_back('{x: 10'd0, y: 9'd0, r: 8'(XS + OFS), g: 8'(YS + OFS), b: old_salt});
    salt = 8'($urandom);
    expect_frame(SH);
    send_frame(SH);
    flush(8);
    compare_writes("drain");
    check("drain_done", 64'(done_cnt), 64'(1));
    check("ovf_sticky", 64'(overflow), 64'(1));
    pulse_start();
    check("ovf_cleared", 64'(overflow), 64'(0));
    check("start_busy", 64'(busy), 64'(1));

    // Short frame (vs after 20 lines): rows 0..1 written, no frame_done, then a full frame.
    ready_mode = 1;
    done_cnt   = 0;
    salt       = 8'($urandom);
    expect_frame(20);
    send_frame(20);
    flush(4);
    check("short_busy", 64'(busy), 64'(1));
    check("short_no_done", 64'(done_cnt), 64'(0));
    salt = 8'($urandom);
    expect_frame(SH);
    send_frame(SH);
    flush(8);
    compare_writes("short");
    check("short_done", 64'(done_cnt), 64'(1));
    check("short_idle", 64'(busy), 64'(0));

    // Reset mid-line during capture, then frames without start.
    ready_mode = 0;
    done_cnt   = 0;
    salt       = 8'($urandom);
    pulse_start();
    expect_frame(7);
    send_frame(7);
    line_part(7, 0, 20);
    reset_n = 1'b0;
    tick();
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_wr_en", 64'(wr_en), 64'(0));
    check("mrst_done", 64'(frame_done), 64'(0));
    check("mrst_wr", 64'({wr_x, wr_y, wr_r, wr_g, wr_b}), 64'(0));
    reset_n = 1'b1;
    line_part(7, 20, SW);
    send_frame(SH);
    send_frame(SH);
    flush(8);
    compare_writes("mrst");
    check("mrst_no_done", 64'(done_cnt), 64'(0));
    check("mrst_idle", 64'(busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
